pipe_stage_skid: RTL

//  Generic parametrised pipeline stage register that replaces hand-written per-stage latch blocks.

---
 rtl/pipe_stage_skid.sv | 112 +++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a valid/ready handshake and an optional
// one-entry skid buffer.
//
// Parameters
//   WIDTH        payload width in bits
//   SKID         1: two-entry elastic stage, in_ready_o registered
//                0: single register, in_ready_o combinational from out_ready_i
//   CLR_PAYLOAD  1: payload registers cleared on flush; 0: payload held, valids cleared
//
// Ports
//   clk, rst           clock and synchronous active-high reset
//   flush_i            flush, only honoured when out_ready_i is high (stall wins)
//   exception_flush_i  flush, always honoured
//   in_valid_i/in_ready_o/in_data_i     upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o  downstream handshake and payload (main register)
//   occupancy_o        number of held beats (0..2)
module pipe_stage_skid #(
  parameter int unsigned WIDTH       = 256,
  parameter int unsigned SKID        = 1,
  parameter int unsigned CLR_PAYLOAD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             exception_flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occupancy_o
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             kill;

  // A stalled flush has no effect; the exception flush always kills.
  assign kill = exception_flush_i | (flush_i & out_ready_i);

  always_comb begin
    if (SKID != 0) begin
      in_ready_o = ~skid_valid_q;
    end else begin
      in_ready_o = ~main_valid_q | out_ready_i;
    end
  end

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (kill) begin
      // Held entries and any same-cycle input beat are dropped.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      if (CLR_PAYLOAD != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else if (skid_valid_q) begin
      // Full: input is refused, skid refills main once downstream drains.
      if (out_ready_i) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (out_ready_i) begin
        if (in_valid_i) begin
          main_d = in_data_i;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (in_valid_i && (SKID != 0)) begin
        skid_d       = in_data_i;
        skid_valid_d = 1'b1;
      end
    end else if (in_valid_i) begin
      main_d       = in_data_i;
      main_valid_d = 1'b1;
    end
  end

  // Payload is always zeroed on reset so outputs are X-free for either CLR_PAYLOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_q;
  assign occupancy_o = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  a_skid_implies_main: assert property (@(posedge clk) disable iff (rst)
    skid_valid_q |-> main_valid_q);
  a_no_skid_when_disabled: assert property (@(posedge clk) disable iff (rst)
    (SKID == 0) |-> !skid_valid_q);

endmodule
